// File: rtl/call_return_stack.sv
// Hardware return-address stack for call/ret. The top entry is shown combinationally on pop_addr.
// Push, pop and replace-top take effect at the clock edge.
module call_return_stack #(
    parameter  int DEPTH = 16,
    parameter  int AW    = 32,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_addr,
    input  logic          clr_err,
    output logic [AW-1:0] pop_addr,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam int IW = $clog2(DEPTH);

    logic [AW-1:0] mem [DEPTH];
    logic [CW-1:0] sp;
    logic [CW-1:0] sp_next;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] wr_idx;
    logic          wr_en;
    logic          ovf_set;
    logic          unf_set;

    assign empty   = (sp == '0);
    assign full    = (sp == CW'(DEPTH));
    assign count   = sp;
    assign top_idx = IW'(sp - CW'(1));

    assign pop_addr = empty ? '0 : mem[top_idx];

    // NOTE: every signal gets a default before the decode so no path leaves it unassigned (no latch).
    always_comb begin
        sp_next = sp;
        wr_en   = 1'b0;
        wr_idx  = '0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push && pop) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            sp_next = CW'(1);
            unf_set = 1'b1;
        end else if (push && !full) begin
            wr_en   = 1'b1;
            wr_idx  = IW'(sp);
            sp_next = sp + CW'(1);
        end else if (push) begin
            ovf_set = 1'b1;
        end else if (pop && !empty) begin
            sp_next = sp - CW'(1);
        end else if (pop) begin
            unf_set = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            // A fresh error beats clr_err; the other flag still clears.
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

    // NOTE: the array is deliberately not reset; pop_addr masks it to 0 until sp covers a written entry.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem[wr_idx] <= push_addr;
        end
    end

endmodule
